// File: rtl/timer_sched_pkg.sv
// Shared types and constants for the timer_scheduler slice.
package timer_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      DONE
   } state_t;

   localparam int unsigned CNT_W_DEF   = 24;
   localparam int unsigned NUM_REQ_MAX = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot round-robin grant; search starts at ptr and wraps.
module rr_arbiter #(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               grant_any
);

   int unsigned idx;

   always_comb begin
      grant     = '0;
      grant_id  = '0;
      grant_any = 1'b0;
      idx       = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = (32'(ptr) + i) % NUM_REQ;
         if (!grant_any && req[idx]) begin
            grant[idx] = 1'b1;
            grant_id   = idx[ID_W-1:0];
            grant_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/timer_scheduler.sv
// One shared interval counter serving NUM_REQ requesters round-robin.
// Optional abort support is compiled in with TIMER_SCHED_ABORT_EN.
module timer_scheduler
   import timer_sched_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   parameter  int unsigned CNT_W   = CNT_W_DEF,
   localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*CNT_W-1:0] req_len,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [NUM_REQ-1:0]       done,
   output logic                     busy,
   output logic [ID_W-1:0]          active_id
`ifdef TIMER_SCHED_ABORT_EN
   ,
   input  logic [NUM_REQ-1:0]       abort,
   output logic [NUM_REQ-1:0]       aborted
`endif
);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]     len_q, len_d;
   logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]      active_id_q, active_id_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic [ID_W-1:0]      ptr_next;
   logic [NUM_REQ-1:0]   grant;
   logic [ID_W-1:0]      grant_id;
   logic                 grant_any;
`ifdef TIMER_SCHED_ABORT_EN
   logic [NUM_REQ-1:0]   aborted_q, aborted_d;
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req       (req_valid),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_id  (grant_id),
      .grant_any (grant_any)
   );

   // Gated by rst_n so no grant is offered while reset is held.
   assign req_ready = (rst_n && state_q == IDLE) ? grant : '0;
   assign ptr_next  = (active_id_q == ID_W'(NUM_REQ - 1)) ? '0 : active_id_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      rr_ptr_d    = rr_ptr_q;
      active_id_d = active_id_q;
      done_d      = '0;
`ifdef TIMER_SCHED_ABORT_EN
      aborted_d   = '0;
`endif
      case (state_q)
         IDLE: begin
            if (grant_any) begin
               len_d       = req_len[grant_id*CNT_W +: CNT_W];
               active_id_d = grant_id;
               cnt_d       = '0;
               state_d     = COUNT;
            end
         end
         COUNT: begin
`ifdef TIMER_SCHED_ABORT_EN
            if (abort[active_id_q]) begin
               aborted_d[active_id_q] = 1'b1;
               rr_ptr_d               = ptr_next;
               active_id_d            = '0;
               state_d                = IDLE;
            end else
`endif
            if (cnt_q == len_q) begin
               done_d[active_id_q] = 1'b1;
               state_d             = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            rr_ptr_d    = ptr_next;
            active_id_d = '0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         len_q       <= '0;
         rr_ptr_q    <= '0;
         active_id_q <= '0;
         done_q      <= '0;
`ifdef TIMER_SCHED_ABORT_EN
         aborted_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         rr_ptr_q    <= rr_ptr_d;
         active_id_q <= active_id_d;
         done_q      <= done_d;
`ifdef TIMER_SCHED_ABORT_EN
         aborted_q   <= aborted_d;
`endif
      end
   end

   assign done      = done_q;
   assign busy      = (state_q != IDLE);
   assign active_id = active_id_q;
`ifdef TIMER_SCHED_ABORT_EN
   assign aborted   = aborted_q;
`endif

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler (CNT_W shrunk to 8); abort checks under TIMER_SCHED_ABORT_EN.
module tb_timer_scheduler;

   localparam int unsigned N = 4;
   localparam int unsigned W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [N-1:0]     req_valid;
   logic [N*W-1:0]   req_len;
   logic [N-1:0]     req_ready;
   logic [N-1:0]     done;
   logic             busy;
   logic [1:0]       active_id;
`ifdef TIMER_SCHED_ABORT_EN
   logic [N-1:0]     abort;
   logic [N-1:0]     aborted;
`endif

   always #5 clk = ~clk;

   timer_scheduler #(
      .NUM_REQ (N),
      .CNT_W   (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_len   (req_len),
      .req_ready (req_ready),
      .done      (done),
      .busy      (busy),
      .active_id (active_id)
`ifdef TIMER_SCHED_ABORT_EN
      ,
      .abort     (abort),
      .aborted   (aborted)
`endif
   );

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   typedef struct {
      int unsigned id;
      int unsigned len;
   } vec_t;

   vec_t tbl [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400; i++) begin
         if (!busy) break;
         tick();
      end
      check("idle_wait", 32'(busy), 32'd0);
   endtask

   // Single request from id; done must land exactly len+1 cycles after the accept edge.
   task automatic run_single(input int unsigned id, input int unsigned len);
      logic [N-1:0] onehot;
      logic [W-1:0] l;
      int unsigned  early;
      onehot     = '0;
      onehot[id] = 1'b1;
      l          = len[W-1:0];
      req_len    = '0;
      req_len[id*W +: W] = l;
      req_valid  = onehot;
      #1;
      check("single_ready", 32'(req_ready), 32'(onehot));
      tick();
      req_valid = '0;
      req_len   = '1;
      early     = 0;
      for (int unsigned k = 0; k < len; k++) begin
         tick();
         if (done != '0) early++;
      end
      tick();
      check("single_no_early_done", early, 32'd0);
      check("single_done", 32'(done), 32'(onehot));
      check("single_done_busy", 32'(busy), 32'd1);
      check("single_done_id", 32'(active_id), id);
      tick();
      check("single_after_done", 32'(done), 32'd0);
      check("single_after_busy", 32'(busy), 32'd0);
      check("single_after_id", 32'(active_id), 32'd0);
   endtask

   initial begin
      int unsigned ids [$];
      int unsigned times [$];
      int unsigned exp_ids [5];
      int unsigned flag;

      tbl[0] = '{id: 2, len: 5};
      tbl[1] = '{id: 0, len: 0};
      tbl[2] = '{id: 3, len: 255};
      tbl[3] = '{id: 1, len: 1};
      tbl[4] = '{id: 2, len: 7};
      exp_ids = '{0, 1, 2, 3, 0};

      // Reset with every requester valid
      rst_n     = 1'b0;
      req_valid = '1;
      req_len   = {N{8'd3}};
`ifdef TIMER_SCHED_ABORT_EN
      abort     = '0;
`endif
      tick();
      tick();
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_active_id", 32'(active_id), 32'd0);

      // Fairness: all valid, len=3
      rst_n = 1'b1;
      #1;
      check("fair_first_ready", 32'(req_ready), 32'b0001);
      for (int unsigned t = 1; t <= 35; t++) begin
         tick();
         if (done != '0) begin
            for (int unsigned b = 0; b < N; b++)
               if (done[b]) ids.push_back(b);
            times.push_back(t);
         end
      end
      req_valid = '0;
      wait_idle();
      check("fair_first_done_time", (times.size() > 0) ? times[0] : 32'd999, 32'd5);
      for (int unsigned i = 0; i < 5; i++)
         check("fair_id", (i < ids.size()) ? ids[i] : 32'd99, exp_ids[i]);
      for (int unsigned i = 1; i < 5; i++)
         check("fair_spacing", (i < times.size()) ? times[i] - times[i-1] : 32'd999, 32'd6);

      // Table of single requests, including len=0 and len=255
      for (int unsigned v = 0; v < 5; v++) begin
         run_single(tbl[v].id, tbl[v].len);
      end

      // Reset mid-count: req 1, len=100, reset at count 40
      req_len = '0;
      req_len[1*W +: W] = 8'd100;
      req_valid = 4'b0010;
      #1;
      tick();
      req_valid = '0;
      flag = 0;
      for (int unsigned k = 0; k < 40; k++) begin
         tick();
         if (done != '0) flag++;
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_active_id", 32'(active_id), 32'd0);
      for (int unsigned k = 0; k < 70; k++) begin
         tick();
         if (done != '0) flag++;
      end
      check("midrst_no_done", flag, 32'd0);
      run_single(1, 5);

`ifdef TIMER_SCHED_ABORT_EN
      // Abort: req 0 (len 50) and req 1 both valid after a fresh reset
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      req_len = '0;
      req_len[0*W +: W] = 8'd50;
      req_len[1*W +: W] = 8'd2;
      req_valid = 4'b0011;
      #1;
      check("abort_first_ready", 32'(req_ready), 32'b0001);
      tick();
      req_valid = 4'b0010;
      for (int unsigned k = 0; k < 5; k++) tick();
      abort = 4'b1000;
      tick();
      abort = '0;
      check("abort_nonowner_busy", 32'(busy), 32'd1);
      check("abort_nonowner_aborted", 32'(aborted), 32'd0);
      for (int unsigned k = 0; k < 4; k++) tick();
      abort = 4'b0001;
      tick();
      abort = '0;
      check("abort_pulse", 32'(aborted), 32'b0001);
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      #1;
      check("abort_next_ready", 32'(req_ready), 32'b0010);
      tick();
      req_valid = '0;
      check("abort_pulse_end", 32'(aborted), 32'd0);
      check("abort_next_owner", 32'(active_id), 32'd1);
      wait_idle();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/timer_scheduler.md
# timer_scheduler

Shares a single interval counter among `NUM_REQ` requesters (UART bit/frame timing, HBM heating phase dwell timers) so the design needs one wide counter instead of one per client. Each requester posts a delay length; a round-robin arbiter grants one request at a time. The block counts the granted length and returns a one-cycle `done` pulse to the owning requester. It sits between the UART/heater control FSMs and replaces their private timer instances.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `CNT_W`, default 24: counter and length width.
- `clk`  in  1: single clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req_valid`  in  NUM_REQ: per-requester delay request.
- `req_len`  in  NUM_REQ*CNT_W: lengths, requester i at bits [i*CNT_W +: CNT_W].
- `req_ready`  out  NUM_REQ: one-hot grant; request i accepted on a cycle with `req_valid[i] & req_ready[i]`.
- `done`  out  NUM_REQ: one-cycle completion pulse to the owner.
- `busy`  out  1: high in any state but IDLE.
- `active_id`  out  $clog2(NUM_REQ): owner of the current count; 0 when idle.
- `abort`  in  NUM_REQ: present only with `TIMER_SCHED_ABORT_EN`.
- `aborted`  out  NUM_REQ: present only with `TIMER_SCHED_ABORT_EN`.

## Operation
- FSM states: IDLE, COUNT, DONE.
- IDLE
  - `req_ready` is combinational: a one-hot bit for the round-robin winner among asserted `req_valid`, searching from `rr_ptr`. It is all-zero when no request is pending.
  - On accept, latch `req_len[winner]` into `len_q`, set `active_id` to the winner, clear `cnt`, and go to COUNT.
- COUNT
  - If `cnt != len_q`, then `cnt <= cnt + 1`.
  - If `cnt == len_q`, go to DONE.
  - `cnt` never exceeds `len_q`, so it never wraps. The full CNT_W range is legal.
- DONE
  - `done[active_id]` = 1 for exactly this cycle.
  - Set `rr_ptr` to `active_id + 1`, wrapping modulo NUM_REQ.
  - Go to IDLE.
- `req_ready` is 0 outside IDLE. A requester dropping `req_valid` before accept is simply not served; there is no queue.
- A requester may re-request in the IDLE cycle after its `done`. Round-robin still favours the next index.
- `req_len` changes after accept have no effect.

## Timing
- Reset values: state IDLE, `cnt` 0, `len_q` 0, `rr_ptr` 0, `done` 0, `aborted` 0, `busy` 0, `active_id` 0.
- A reset mid-count returns to IDLE and no `done` is issued.
- Latency: with accept at edge E, `done` is high in the cycle after edge E+len+1.
  - len=0 gives `done` in the cycle after E+1.
- Minimum request-to-request period is len+3 cycles: accept, COUNT cycles, DONE, IDLE.
- `done`, `busy` and `active_id` are registered.
- Simultaneous valid requests: exactly one is granted. The others hold `req_valid` and wait.

## Configuration
- `TIMER_SCHED_ABORT_EN` defined:
  - Adds the `abort` and `aborted` ports.
  - If `abort[active_id]` is sampled during COUNT, go to IDLE next edge. `aborted[active_id]` pulses one cycle, no `done` is issued, and `rr_ptr` advances as for `done`.
  - `abort` for a non-owner, or outside COUNT, is ignored.
  - Abort and `cnt == len_q` in the same cycle: abort wins.
- Not defined: no abort ports. Every accepted request completes with `done`.

## Structure
- Package `timer_sched_pkg` holds:
  - the `state_t` enum (IDLE, COUNT, DONE);
  - `CNT_W_DEF = 24`;
  - the `NUM_REQ_MAX = 8` constant.
- Sub-module `rr_arbiter`: combinational one-hot round-robin grant from a request vector and `rr_ptr`. The pointer register stays in `timer_scheduler`.
- Expected size is about 150–250 lines of RTL.

## Test plan
- Reset: assert `rst_n`=0 for 2 cycles with all `req_valid`=1 -> `req_ready`=0, `done`=0, `busy`=0, `active_id`=0.
- Single request, req 2 with len=5 accepted at edge E -> `done[2]` high only in the cycle after E+6; `busy` low again one cycle later.
- len=0 and len=2^CNT_W-1 (shrink CNT_W to 8 in the bench, i.e. 255) -> `done` after 1 and 256 cycles respectively, with no counter wrap.
- Fairness: all 4 requesters continuously valid with len=3 -> grants in order 0,1,2,3,0, each `done` 6 cycles apart.
- Reset mid-count: req 1 with len=100, `rst_n` low at count 40 -> no `done[1]`; after release, a new req 1 is served from 0.
- With `TIMER_SCHED_ABORT_EN`, req 0 with len=50:
  - `abort[0]` at count 10 -> `aborted[0]` pulses, no `done`, next grant goes to req 1.
  - `abort[3]` during the same count -> ignored.
